md_unit: RTL

- Multi-cycle multiply/divide unit in the EX stage, operating alongside the ALU.
- Takes the same forwarded operands A/B and executes mult, multu, div and divu over a fixed number of cycles. Results go into the architectural HI/LO registers.
- Also services mthi/mtlo writes and mfhi/mflo reads.
- Exposes Busy to the hazard unit so that later HI/LO accesses stall in ID.

---
 rtl/md_unit_if.sv | 13 +
 rtl/md_unit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/md_unit_if.sv
// Operand/result bundle between the EX stage and the multiply/divide unit.
interface md_unit_if;
   logic [31:0] A;
   logic [31:0] B;
   logic [3:0]  MDOp;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] Out;

   modport master (output A, B, MDOp, input Busy, HI, LO, Out);
   modport slave  (input A, B, MDOp, output Busy, HI, LO, Out);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; result computed at start,
// committed after a fixed latency so Busy timing matches the original pipeline.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   md_unit_if.slave   md
);
   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   typedef enum logic {IDLE, RUN} state_t;

   logic [CW-1:0] cnt, cnt_n;
   logic [31:0]   hi, hi_n, lo, lo_n;
   logic [31:0]   pend_hi, pend_hi_n, pend_lo, pend_lo_n;
   logic          pend_dz, pend_dz_n;
   state_t        state;

   assign state = (cnt != '0) ? RUN : IDLE;

   // Datapath results, evaluated from the live operands at the start edge.
   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic               a_neg, b_neg, b_zero;
   logic        [31:0] a_mag, b_mag, b_safe, bu_safe;
   logic        [31:0] uq, ur, sq, sr, dq, dr;

   assign prod_s  = $signed(md.A) * $signed(md.B);
   assign prod_u  = {32'd0, md.A} * {32'd0, md.B};
   assign b_zero  = (md.B == 32'd0);
   assign a_neg   = md.A[31];
   assign b_neg   = md.B[31];
   assign a_mag   = a_neg ? (32'd0 - md.A) : md.A;
   assign b_mag   = b_neg ? (32'd0 - md.B) : md.B;
   // Divisor forced to 1 on divide-by-zero; the result is discarded anyway.
   assign b_safe  = b_zero ? 32'd1 : b_mag;
   assign bu_safe = b_zero ? 32'd1 : md.B;
   assign uq      = a_mag / b_safe;
   assign ur      = a_mag % b_safe;
   assign sq      = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
   assign sr      = a_neg ? (32'd0 - ur) : ur;
   assign dq      = md.A / bu_safe;
   assign dr      = md.A % bu_safe;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         hi      <= '0;
         lo      <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_dz <= 1'b0;
      end else begin
         cnt     <= cnt_n;
         hi      <= hi_n;
         lo      <= lo_n;
         pend_hi <= pend_hi_n;
         pend_lo <= pend_lo_n;
         pend_dz <= pend_dz_n;
      end
   end

   always_comb begin
      cnt_n     = cnt;
      hi_n      = hi;
      lo_n      = lo;
      pend_hi_n = pend_hi;
      pend_lo_n = pend_lo;
      pend_dz_n = pend_dz;
      unique case (state)
         IDLE: begin
            case (md.MDOp)
               OP_MULT: begin
                  {pend_hi_n, pend_lo_n} = prod_s;
                  pend_dz_n = 1'b0;
                  cnt_n     = CW'(MULT_CYCLES);
               end
               OP_MULTU: begin
                  {pend_hi_n, pend_lo_n} = prod_u;
                  pend_dz_n = 1'b0;
                  cnt_n     = CW'(MULT_CYCLES);
               end
               OP_DIV: begin
                  pend_hi_n = sr;
                  pend_lo_n = sq;
                  pend_dz_n = b_zero;
                  cnt_n     = CW'(DIV_CYCLES);
               end
               OP_DIVU: begin
                  pend_hi_n = dr;
                  pend_lo_n = dq;
                  pend_dz_n = b_zero;
                  cnt_n     = CW'(DIV_CYCLES);
               end
               OP_MTHI: hi_n = md.A;
               OP_MTLO: lo_n = md.A;
               default: ;
            endcase
         end
         RUN: begin
            // Writes and new starts are ignored while running.
            if (cnt == CW'(1)) begin
               cnt_n = '0;
               if (!pend_dz) begin
                  hi_n = pend_hi;
                  lo_n = pend_lo;
               end
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         default: ;
      endcase
   end

   assign md.Busy = (state == RUN);
   assign md.HI   = hi;
   assign md.LO   = lo;
   assign md.Out  = (md.MDOp == OP_MFHI) ? hi :
                    (md.MDOp == OP_MFLO) ? lo : 32'd0;
endmodule
